pwm_capture: RTL



---
 rtl/pwm_capture.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in i_clk
// cycles and reports them, plus overflow/timeout status, through a 16-bit Wishbone slave.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pwm,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [15:0] i_wb_data,
    output logic [15:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_valid,
    output logic        o_irq
);

    localparam logic [15:0] ADR_CTRL    = 16'h0000;
    localparam logic [15:0] ADR_STATUS  = 16'h0002;
    localparam logic [15:0] ADR_HIGH    = 16'h0004;
    localparam logic [15:0] ADR_PERIOD  = 16'h0006;
    localparam logic [15:0] ADR_TIMEOUT = 16'h0008;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [15:0] zext(input logic [CNT_W-1:0] v);
        return 16'(v);
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   lvl_p0;
    logic                   lvl_p1;
    logic                   rise;
    logic                   fall;

    logic                   ctrl_en;
    logic                   ctrl_irq_en;
    logic                   ctrl_one_shot;
    logic [15:0]            timeout_reg;

    logic                   status_valid;
    logic                   status_ovf;
    logic                   status_tmo;
    logic                   status_lvl;
    logic [2:0]             w1c;

    logic [CNT_W-1:0]       high_reg;
    logic [CNT_W-1:0]       period_reg;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [2:0]             state;

    logic [2:0]             state_nx;
    logic [CNT_W-1:0]       cnt_nx;
    logic [CNT_W-1:0]       hi_cnt_nx;
    logic                   set_valid;
    logic                   set_ovf;
    logic                   set_tmo;
    logic                   load_res;
    logic                   tmo_hit;
    logic                   cnt_sat;

    logic                   access;
    logic                   wr_en;
    logic                   rd_en;
    logic [15:0]            rd_data;

    // Input synchronizer, then one extra flop for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= '0;
            lvl_p1  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_pwm};
            lvl_p1  <= lvl_p0;
        end
    end

    assign lvl_p0 = sync_p0[SYNC_STAGES-1];
    assign rise   = lvl_p0 & ~lvl_p1;
    assign fall   = ~lvl_p0 & lvl_p1;

    assign tmo_hit = (timeout_reg != 16'h0000) && (zext(cnt) == timeout_reg);
    assign cnt_sat = &cnt;

    // Edges take priority over saturation and timeout in every measuring state.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_cnt_nx = hi_cnt;
        set_valid = 1'b0;
        set_ovf   = 1'b0;
        set_tmo   = 1'b0;
        load_res  = 1'b0;
        if (!ctrl_en) begin
            state_nx  = S_IDLE;
            cnt_nx    = '0;
            hi_cnt_nx = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx  = S_ARM;
                    cnt_nx    = '0;
                    hi_cnt_nx = '0;
                end
                S_ARM: begin
                    if (rise) begin
                        state_nx = S_HI;
                        cnt_nx   = CNT_ONE;
                    end else if (tmo_hit) begin
                        set_tmo = 1'b1;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = sat_inc(cnt);
                    end
                end
                S_HI: begin
                    if (fall) begin
                        hi_cnt_nx = cnt;
                        state_nx  = S_LO;
                        cnt_nx    = sat_inc(cnt);
                    end else if (cnt_sat) begin
                        set_ovf  = 1'b1;
                        state_nx = S_ARM;
                        cnt_nx   = '0;
                    end else if (tmo_hit) begin
                        set_tmo  = 1'b1;
                        state_nx = S_ARM;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = sat_inc(cnt);
                    end
                end
                S_LO: begin
                    if (rise) begin
                        load_res  = 1'b1;
                        set_valid = 1'b1;
                        cnt_nx    = CNT_ONE;
                        state_nx  = ctrl_one_shot ? S_HOLD : S_HI;
                    end else if (cnt_sat) begin
                        set_ovf  = 1'b1;
                        state_nx = S_ARM;
                        cnt_nx   = '0;
                    end else if (tmo_hit) begin
                        set_tmo  = 1'b1;
                        state_nx = S_ARM;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = sat_inc(cnt);
                    end
                end
                S_HOLD: begin
                    cnt_nx = '0;
                    if (!status_valid) state_nx = S_ARM;
                end
                default: begin
                    state_nx  = S_IDLE;
                    cnt_nx    = '0;
                    hi_cnt_nx = '0;
                end
            endcase
        end
    end

    // Measurement state and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hi_cnt     <= '0;
            high_reg   <= '0;
            period_reg <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi_cnt <= hi_cnt_nx;
            if (load_res) begin
                period_reg <= cnt;
                high_reg   <= hi_cnt;
            end
        end
    end

    assign access = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr_en  = access & i_wb_we;
    assign rd_en  = access & ~i_wb_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_en       <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_one_shot <= 1'b0;
            timeout_reg   <= 16'h0000;
        end else if (wr_en) begin
            if (i_wb_adr == ADR_CTRL) begin
                ctrl_en       <= i_wb_data[0];
                ctrl_irq_en   <= i_wb_data[1];
                ctrl_one_shot <= i_wb_data[2];
            end
            if (i_wb_adr == ADR_TIMEOUT) timeout_reg <= i_wb_data;
        end
    end

    always_comb begin
        w1c = 3'b000;
        if (wr_en && (i_wb_adr == ADR_STATUS)) w1c = i_wb_data[2:0];
    end

    // A hardware set in the same cycle as a write-one-to-clear keeps the bit set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            status_valid <= 1'b0;
            status_ovf   <= 1'b0;
            status_tmo   <= 1'b0;
            status_lvl   <= 1'b0;
        end else begin
            status_valid <= set_valid | (status_valid & ~w1c[0]);
            status_ovf   <= set_ovf   | (status_ovf   & ~w1c[1]);
            status_tmo   <= set_tmo   | (status_tmo   & ~w1c[2]);
            if (set_tmo) status_lvl <= lvl_p0;
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        case (i_wb_adr)
            ADR_CTRL:    rd_data = {13'h0000, ctrl_one_shot, ctrl_irq_en, ctrl_en};
            ADR_STATUS:  rd_data = {12'h000, status_lvl, status_tmo, status_ovf, status_valid};
            ADR_HIGH:    rd_data = zext(high_reg);
            ADR_PERIOD:  rd_data = zext(period_reg);
            ADR_TIMEOUT: rd_data = timeout_reg;
            default:     rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 16'h0000;
        end else begin
            o_wb_ack <= i_wb_cyc & i_wb_stb & ~o_wb_ack;
            if (rd_en) o_wb_data <= rd_data;
        end
    end

    assign o_valid = status_valid;
    assign o_irq   = ctrl_irq_en & (status_valid | status_ovf | status_tmo);

endmodule
